// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: single-port SRAM behind a dBus command/response handshake.
// One command in flight; response pulses LATENCY cycles after accept.
module dbus_sram_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dBus_cmd_valid,
   output logic        dBus_cmd_ready,
   input  logic [31:0] dBus_cmd_payload_addr,
   input  logic [31:0] dBus_cmd_payload_data,
   input  logic [3:0]  dBus_cmd_payload_size,
   input  logic        dBus_cmd_payload_wr,
   output logic        dBus_rsp_valid,
   output logic [31:0] dBus_rsp_data,
   output logic        dBus_rsp_error
);
   localparam int          AW   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);
   localparam logic [2:0]  LAT  = 3'(LATENCY);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d, data_q, data_d;
   logic [3:0]  size_q, size_d;
   logic        wr_q, wr_d;
   logic        rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic [31:0] mem_q [DEPTH_WORDS];

   logic [31:0] rel, word, wdata, rdata, mask;
   logic [1:0]  off;
   logic [3:0]  lanes;
   logic [AW-1:0] idx;
   logic        err, fire;

   always_comb begin
      rel   = addr_q - BASE_ADDR;
      off   = addr_q[1:0];
      idx   = rel[AW+1:2];
      word  = mem_q[idx];
      lanes = size_q << off;
      wdata = data_q << {off, 3'b000};
      mask  = size_q == 4'b0001 ? 32'h0000_00ff : size_q == 4'b0011 ? 32'h0000_ffff : 32'hffff_ffff;
      rdata = (word >> {off, 3'b000}) & mask;
      err   = ({1'b0, rel} >= SPAN)
            || !(size_q == 4'b0001 || size_q == 4'b0011 || size_q == 4'b1111)
            || (size_q == 4'b0011 && off[0])
            || (size_q == 4'b1111 && off != 2'b00);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      data_d      = data_q;
      size_d      = size_q;
      wr_d        = wr_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = '0;
      rsp_error_d = 1'b0;
      fire        = 1'b0;
      if (state_q == IDLE) begin
         if (dBus_cmd_valid) begin
            state_d = WAIT;
            cnt_d   = LAT;
            addr_d  = dBus_cmd_payload_addr;
            data_d  = dBus_cmd_payload_data;
            size_d  = dBus_cmd_payload_size;
            wr_d    = dBus_cmd_payload_wr;
         end
      end else if (cnt_q == 3'd1) begin
         fire        = 1'b1;
         state_d     = IDLE;
         cnt_d       = '0;
         rsp_valid_d = 1'b1;
         rsp_error_d = err;
         rsp_data_d  = (err || wr_q) ? '0 : rdata;
      end else begin
         cnt_d = cnt_q - 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         size_q      <= '0;
         wr_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         size_q      <= size_d;
         wr_q        <= wr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   // Memory has no reset; a reset on the response edge suppresses the commit.
   always_ff @(posedge clk) begin
      if (!rst && fire && wr_q && !err)
         for (int i = 0; i < 4; i++)
            if (lanes[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
   end

   assign dBus_cmd_ready = (state_q == IDLE);
   assign dBus_rsp_valid = rsp_valid_q;
   assign dBus_rsp_data  = rsp_data_q;
   assign dBus_rsp_error = rsp_error_q;
endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb_dbus_sram_responder: three responders (LATENCY 1,2,3) checked against a byte-array model.
module tb_dbus_sram_responder;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic [2:0]  v = '0, rdy, rv, re;
   logic [31:0] rd [3];
   logic [31:0] a_i = '0, d_i = '0;
   logic [3:0]  s_i = '0;
   logic        w_i = 1'b0;
   logic [7:0]  mb [3][64];
   int passed = 0, total = 0, fails = 0;

   for (genvar g = 0; g < 3; g++) begin : u
      dbus_sram_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(g + 1)) dut (
         .clk(clk), .rst(rst),
         .dBus_cmd_valid(v[g]), .dBus_cmd_ready(rdy[g]),
         .dBus_cmd_payload_addr(a_i), .dBus_cmd_payload_data(d_i),
         .dBus_cmd_payload_size(s_i), .dBus_cmd_payload_wr(w_i),
         .dBus_rsp_valid(rv[g]), .dBus_rsp_data(rd[g]), .dBus_rsp_error(re[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Memory is 64 bytes at address 0; a command touches n consecutive bytes.
   function automatic void model(input int k, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input logic w,
                                 output logic [31:0] exp_d, output logic exp_e);
      int n;
      n = s == 4'd1 ? 1 : s == 4'd3 ? 2 : 4;
      exp_e = (a >= 32'd64) || !(s == 4'd1 || s == 4'd3 || s == 4'd15) || (a % n != 0);
      exp_d = '0;
      if (!exp_e)
         for (int j = 0; j < n; j++)
            if (w) mb[k][a + j] = d[8*j +: 8];
            else exp_d[8*j +: 8] = mb[k][a + j];
   endfunction

   task automatic cmd(input int k, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic w);
      logic [31:0] ed;
      logic ee;
      @(negedge clk);
      chk("pre_ready", rdy[k], 1);
      a_i = a; d_i = d; s_i = s; w_i = w; v[k] = 1'b1;
      model(k, a, d, s, w, ed, ee);
      @(posedge clk); #1;
      v[k] = 1'b0;
      a_i = $urandom; d_i = $urandom; s_i = 4'($urandom); w_i = 1'($urandom);
      chk("acc_ready", rdy[k], 0);
      chk("acc_rv", rv[k], 0);
      for (int j = 1; j <= k + 1; j++) begin
         @(posedge clk); #1;
         chk("lat_rv", rv[k], 32'(j == k + 1));
         chk("lat_ready", rdy[k], 32'(j == k + 1));
      end
      chk("rsp_data", rd[k], ed);
      chk("rsp_err", re[k], 32'(ee));
      @(posedge clk); #1;
      chk("post_rv", rv[k], 0);
      chk("post_data", rd[k], 0);
      chk("post_err", re[k], 0);
   endtask

   initial begin
      logic [31:0] ed;
      logic ee;
      logic [3:0] sz [7] = '{4'd1, 4'd3, 4'd15, 4'd1, 4'd3, 4'd15, 4'd7};
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", rdy[k], 1);
         chk("rst_rv", rv[k], 0);
         chk("rst_data", rd[k], 0);
         chk("rst_err", re[k], 0);
      end
      @(negedge clk); rst = 1'b0;

      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 16; i++) cmd(k, 32'(4 * i), $urandom, 4'hF, 1'b1);

      cmd(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
      cmd(0, 32'h10, 32'h0, 4'hF, 1'b0);
      cmd(0, 32'h10, 32'h11223344, 4'hF, 1'b1);
      cmd(0, 32'h13, 32'h0000005A, 4'h1, 1'b1);
      cmd(0, 32'h13, 32'h0, 4'h1, 1'b0);
      cmd(0, 32'h10, 32'h0, 4'hF, 1'b0);
      cmd(0, 32'h12, 32'h0, 4'h3, 1'b0);
      chk("byte_merge", {mb[0][8'h13], mb[0][8'h12], mb[0][8'h11], mb[0][8'h10]}, 32'h5A223344);

      cmd(0, 32'h11, 32'hFFFF_FFFF, 4'h3, 1'b1);
      cmd(0, 32'h12, 32'hFFFF_FFFF, 4'hF, 1'b1);
      cmd(0, 32'h10, 32'hFFFF_FFFF, 4'h7, 1'b1);
      cmd(0, 32'h40, 32'hFFFF_FFFF, 4'hF, 1'b1);
      cmd(0, 32'h11, 32'h0, 4'h3, 1'b0);
      cmd(0, 32'h10, 32'h0, 4'hF, 1'b0);

      @(negedge clk);
      rst = 1'b1; v[0] = 1'b1; a_i = 32'h10; d_i = 32'h0BAD0BAD; s_i = 4'hF; w_i = 1'b1;
      @(negedge clk);
      rst = 1'b0; v[0] = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rstcmd_rv", rv[0], 0);
         chk("rstcmd_ready", rdy[0], 1);
      end
      cmd(0, 32'h10, 32'h0, 4'hF, 1'b0);

      @(negedge clk);
      a_i = 32'h20; d_i = 32'hCAFEF00D; s_i = 4'hF; w_i = 1'b1; v[1] = 1'b1;
      @(posedge clk); #1;
      v[1] = 1'b0;
      chk("abort_wait", rdy[1], 0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_rv", rv[1], 0);
      chk("abort_ready", rdy[1], 1);
      @(negedge clk); rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("abort_norsp", rv[1], 0);
      end
      cmd(1, 32'h20, 32'h0, 4'hF, 1'b0);

      @(negedge clk);
      a_i = 32'h24; d_i = 32'h0BADF00D; s_i = 4'hF; w_i = 1'b1; v[1] = 1'b1;
      @(posedge clk); #1;
      v[1] = 1'b0;
      @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("coinc_rv", rv[1], 0);
      chk("coinc_ready", rdy[1], 1);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("coinc_norsp", rv[1], 0);
      cmd(1, 32'h24, 32'h0, 4'hF, 1'b0);

      @(negedge clk);
      a_i = 32'(4 * $urandom_range(0, 15)); s_i = 4'hF; w_i = 1'b0; v[2] = 1'b1;
      model(2, a_i, 32'h0, 4'hF, 1'b0, ed, ee);
      for (int n = 0; n < 16; n++) begin
         @(posedge clk); #1;
         chk("burst_ready", rdy[2], 32'(n % 4 == 3));
         chk("burst_rv", rv[2], 32'(n % 4 == 3));
         if (n % 4 == 3) begin
            chk("burst_data", rd[2], ed);
            chk("burst_err", re[2], 32'(ee));
            if (n < 15) begin
               a_i = 32'($urandom_range(0, 63));
               s_i = 4'h1;
               model(2, a_i, 32'h0, 4'h1, 1'b0, ed, ee);
            end else v[2] = 1'b0;
         end
      end
      @(posedge clk); #1;
      chk("burst_idle_rv", rv[2], 0);
      chk("burst_idle_ready", rdy[2], 1);

      for (int i = 0; i < 60; i++) begin
         int k;
         logic [31:0] a;
         k = $urandom_range(0, 2);
         a = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 79)) : $urandom;
         cmd(k, a, $urandom, sz[$urandom_range(0, 6)], 1'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/dbus_sram_responder.md
DBUS_SRAM_RESPONDER -- requirements
Module: dbus_sram_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0 (aligned to 4*DEPTH_WORDS).
REQ-003 SHALL have parameter LATENCY, default 1, cycles from command accept to response (legal 1..4).
REQ-004 SHALL use one clock and a synchronous, active-high reset (fixed by earlier decision).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 dBus_cmd_valid  input  1  initiator presents command.
REQ-008 dBus_cmd_ready  output  1  responder can accept command.
REQ-009 dBus_cmd_payload_addr  input  32  byte address.
REQ-010 dBus_cmd_payload_data  input  32  write data, LSB-aligned.
REQ-011 dBus_cmd_payload_size  input  4  byte mask: 0001 byte, 0011 half, 1111 word.
REQ-012 dBus_cmd_payload_wr  input  1  1 write, 0 read.
REQ-013 dBus_rsp_valid  output  1  one-cycle response pulse.
REQ-014 dBus_rsp_data  output  32  read data, LSB-aligned.
REQ-015 dBus_rsp_error  output  1  error flag, qualified by rsp_valid.

Function
REQ-016 SHALL implement states IDLE and WAIT; command accepted on a rising edge with cmd_valid & cmd_ready (edge E0).
REQ-017 cmd_ready SHALL be 1 in IDLE, 0 in WAIT; cmd_valid in WAIT ignored, payload changes in WAIT ignored.
REQ-018 On accept SHALL register addr, data, size, wr; enter WAIT; load latency counter.
REQ-019 At edge E0+LATENCY SHALL assert rsp_valid for exactly one cycle and return to IDLE (cmd_ready=1 same cycle); min command spacing LATENCY+1 cycles.
REQ-020 Error SHALL be flagged if: addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS); size not 0001/0011/1111; half with addr[0]=1; word with addr[1:0]!=0.
REQ-021 Word index SHALL be (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2]; lane offset = addr[1:0].
REQ-022 Legal write SHALL commit at edge E0+LATENCY: byte lanes = size<<offset, lane k gets data[8*(k-offset)+7 -: 8]; unselected lanes unchanged.
REQ-023 Legal read SHALL return rsp_data = word>>(8*offset) masked to size width; upper bits zero (initiator sign-extends).
REQ-024 Write response SHALL have rsp_data=0, rsp_error=0.
REQ-025 Error response SHALL have rsp_error=1, rsp_data=0, no memory modification.
REQ-026 rsp_data and rsp_error SHALL be 0 whenever rsp_valid=0.
REQ-027 Read in response cycle SHALL reflect all writes committed on earlier edges.

Reset
REQ-028 While rst=1 on an edge: state=IDLE, dBus_cmd_ready=1 from next cycle, dBus_rsp_valid=0, dBus_rsp_data=0, dBus_rsp_error=0, counter=0.
REQ-029 Reset during WAIT SHALL abort: no response, pending write discarded; reset coincident with E0+LATENCY wins (no commit, no response).
REQ-030 Command presented with rst=1 SHALL not be accepted.
REQ-031 Memory contents SHALL not be cleared by reset; post-reset read of unwritten word is undefined, not X-checked.

Verification
REQ-032 LATENCY=1: write word 0xDEADBEEF @0x10, then read word @0x10 -> rsp_valid one cycle after each accept, read rsp_data=0xDEADBEEF, rsp_error=0.
REQ-033 Byte write 0x5A @0x13 over 0x11223344 @0x10; read byte @0x13 -> 0x0000005A; read word @0x10 -> 0x5A223344; read half @0x12 -> 0x00005A22.
REQ-034 Half read @0x11, word read @0x12, size 0111, addr BASE+4*DEPTH_WORDS -> each rsp_error=1, rsp_data=0; prior word contents unchanged.
REQ-035 LATENCY=3: cmd_valid held high continuously with 4 commands -> accepts spaced 4 cycles apart, rsp_valid exactly 3 cycles after each accept, cmd_ready=0 for 3 cycles each.
REQ-036 Accept write 0xCAFEF00D @0x20 (LATENCY=2), assert rst one cycle later -> no rsp_valid, word @0x20 retains old value on later read.
REQ-037 Reset coincident with response edge -> no rsp_valid, no write commit, cmd_ready=1 next cycle.
